// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: round-robin sharing of one sd_reader sector engine among NREQ requesters
module sd_sector_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 33554432
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_sector,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   out_en,
  output logic [8:0]        out_addr,
  output logic [7:0]        out_byte,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic              rstart,
  output logic [31:0]       rsector,
  input  logic              rbusy,
  input  logic              rdone,
  input  logic              outen,
  input  logic [8:0]        outaddr,
  input  logic [7:0]        outbyte
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t          state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, pick, idx;
  logic [9:0]      byte_cnt_q, byte_cnt_d, byte_inc;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d, done_q, done_d;
  logic            err_q, err_d, rstart_q, rstart_d;
  logic [31:0]     rsector_q, rsector_d;
  assign req_ack  = req_ack_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rstart   = rstart_q;
  assign rsector  = rsector_q;
  assign busy     = state_q != IDLE;
  assign out_addr = outaddr;
  assign out_byte = outbyte;
  assign out_en   = (state_q == READ && outen) ? {{(NREQ-1){1'b0}}, 1'b1} << gnt_q : '0;
  assign byte_inc = !outen ? byte_cnt_q : (byte_cnt_q == 10'h3ff) ? byte_cnt_q : byte_cnt_q + 10'd1;
  always_comb begin
    pick = rr_ptr_q;
    idx  = rr_ptr_q;
    for (int k = NREQ; k >= 1; k--) begin
      idx = GW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_valid[idx]) pick = idx;
    end
  end
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    req_ack_d  = '0;
    done_d     = '0;
    err_d      = err_q;
    rstart_d   = rstart_q;
    rsector_d  = rsector_q;
    case (state_q)
      IDLE: if (|req_valid && !rbusy) begin
        req_ack_d[pick] = 1'b1;
        gnt_d           = pick;
        rsector_d       = req_sector[32*int'(pick) +: 32];
        rstart_d        = 1'b1;
        rr_ptr_d        = pick;
        byte_cnt_d      = '0;
        tmo_cnt_d       = '0;
        state_d         = READ;
      end
      READ: begin
        byte_cnt_d = byte_inc;
        tmo_cnt_d  = tmo_cnt_q + TW'(1);
        if (rdone) begin
          rstart_d      = 1'b0;
          done_d[gnt_q] = 1'b1;
          err_d         = byte_inc != 10'd512;
          state_d       = IDLE;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          rstart_d      = 1'b0;
          done_d[gnt_q] = 1'b1;
          err_d         = 1'b1;
          state_d       = DRAIN;
        end
      end
      DRAIN: state_d = rbusy ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= GW'(NREQ - 1);
      gnt_q      <= '0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      req_ack_q  <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rstart_q   <= 1'b0;
      rsector_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      req_ack_q  <= req_ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rstart_q   <= rstart_d;
      rsector_q  <= rsector_d;
    end
  end
endmodule

// File: tb/tb_sd_sector_arbiter.sv
// tb_sd_sector_arbiter: directed scenario bench for sd_sector_arbiter
module tb_sd_sector_arbiter;
  logic        clk = 0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_sector;
  logic [1:0]  req_ack, out_en, done;
  logic [8:0]  out_addr, outaddr;
  logic [7:0]  out_byte, outbyte;
  logic        err, busy, rstart, rbusy, rdone, outen;
  logic [31:0] rsector;
  int checks = 0, errors = 0;
  int seen0, seen1, bad, ndone, nack;
  sd_sector_arbiter #(.NREQ(2), .TIMEOUT(1000)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sector(req_sector),
    .req_ack(req_ack), .out_en(out_en), .out_addr(out_addr), .out_byte(out_byte),
    .done(done), .err(err), .busy(busy), .rstart(rstart), .rsector(rsector),
    .rbusy(rbusy), .rdone(rdone), .outen(outen), .outaddr(outaddr), .outbyte(outbyte)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; req_valid = 0; req_sector = 0; rbusy = 0; rdone = 0;
    outen = 0; outaddr = 0; outbyte = 0;
    step();
    step();
    rst = 0;
  endtask
  task automatic send_bytes(input int n);
    seen0 = 0; seen1 = 0; bad = 0; ndone = 0; nack = 0;
    for (int i = 0; i < n; i++) begin
      outen = 1; outaddr = 9'(i); outbyte = 8'(i * 7 + 3); rbusy = 1;
      #1;
      if (out_en[0]) seen0++;
      if (out_en[1]) seen1++;
      if (out_en != 0 && (out_addr !== outaddr || out_byte !== outbyte)) bad++;
      if (done != 0) ndone++;
      if (req_ack != 0) nack++;
      step();
    end
    outen = 0;
  endtask
  task automatic test_reset();
    rst = 1; req_valid = 2'b11; req_sector = 64'h1; rbusy = 0; rdone = 0;
    outen = 1; outaddr = 0; outbyte = 0;
    step();
    step();
    checks++;
    if ({req_ack, done, err, rstart, busy, out_en} !== 9'b0 || rsector !== 32'h0) begin
      errors++;
      $display("FAIL reset: ack=%b done=%b err=%b rstart=%b busy=%b out_en=%b rsector=%h expected all 0",
               req_ack, done, err, rstart, busy, out_en, rsector);
    end
  endtask
  task automatic test_single();
    do_reset();
    req_valid = 2'b01; req_sector = {32'h0000_0999, 32'h0000_0800};
    step();
    checks++;
    if (req_ack !== 2'b01 || rstart !== 1 || rsector !== 32'h800 || busy !== 1) begin
      errors++;
      $display("FAIL single_grant: ack=%b rstart=%b rsector=%h busy=%b expected 01 1 00000800 1", req_ack, rstart, rsector, busy);
    end
    req_valid = 0; req_sector = 64'hffff_ffff_ffff_ffff;
    send_bytes(511);
    outen = 1; rdone = 1; #1;
    if (out_en[0]) seen0++;
    if (out_en[1]) seen1++;
    step();
    checks++;
    if (req_ack !== 2'b00) begin errors++; $display("FAIL single_ack_pulse: ack=%b expected 00", req_ack); end
    checks++;
    if (seen0 != 512 || seen1 != 0 || bad != 0) begin
      errors++;
      $display("FAIL single_route: seen0=%0d seen1=%0d bad=%0d expected 512 0 0", seen0, seen1, bad);
    end
    outen = 0; rdone = 0; rbusy = 0;
    checks++;
    if (done !== 2'b01 || err !== 0 || rstart !== 0 || busy !== 0 || rsector !== 32'h800) begin
      errors++;
      $display("FAIL single_done: done=%b err=%b rstart=%b busy=%b rsector=%h expected 01 0 0 0 00000800", done, err, rstart, busy, rsector);
    end
    step();
    checks++;
    if (done !== 2'b00) begin errors++; $display("FAIL single_done_pulse: done=%b expected 00", done); end
  endtask
  task automatic test_contention();
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req_valid = 2'b11; req_sector = {32'h0000_0200, 32'h0000_0100};
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (req_ack !== exp_g[k] || rsector !== (exp_g[k][0] ? 32'h100 : 32'h200)) begin
        errors++;
        $display("FAIL contention_grant%0d: ack=%b rsector=%h expected %b", k, req_ack, rsector, exp_g[k]);
      end
      send_bytes(511);
      outen = 1; rdone = 1; #1;
      if (out_en[0]) seen0++;
      if (out_en[1]) seen1++;
      step();
      outen = 0; rdone = 0; rbusy = 0;
      checks++;
      if ((exp_g[k][0] ? seen0 : seen1) != 512 || (exp_g[k][0] ? seen1 : seen0) != 0) begin
        errors++;
        $display("FAIL contention_route%0d: seen0=%0d seen1=%0d expected 512 to %b only", k, seen0, seen1, exp_g[k]);
      end
      checks++;
      if (done !== exp_g[k] || err !== 0) begin
        errors++;
        $display("FAIL contention_done%0d: done=%b err=%b expected %b 0", k, done, err, exp_g[k]);
      end
    end
    req_valid = 0;
  endtask
  task automatic test_short();
    do_reset();
    req_valid = 2'b01; req_sector = {32'h0000_0020, 32'h0000_0010};
    step();
    req_valid = 0;
    send_bytes(500);
    rdone = 1;
    step();
    rdone = 0; rbusy = 0;
    checks++;
    if (done !== 2'b01 || err !== 1) begin
      errors++;
      $display("FAIL short_done: done=%b err=%b expected 01 1", done, err);
    end
    req_valid = 2'b10;
    step();
    checks++;
    if (req_ack !== 2'b10 || rsector !== 32'h20 || err !== 1) begin
      errors++;
      $display("FAIL short_next_grant: ack=%b rsector=%h err=%b expected 10 00000020 1", req_ack, rsector, err);
    end
    req_valid = 0;
    send_bytes(511);
    outen = 1; rdone = 1;
    step();
    outen = 0; rdone = 0; rbusy = 0;
    checks++;
    if (done !== 2'b10 || err !== 0) begin
      errors++;
      $display("FAIL short_next_done: done=%b err=%b expected 10 0", done, err);
    end
  endtask
  task automatic test_timeout();
    do_reset();
    req_valid = 2'b01; req_sector = {32'h0000_0002, 32'h0000_0001};
    step();
    req_valid = 0;
    send_bytes(999);
    checks++;
    if (ndone != 0 || done !== 2'b00 || seen0 != 999) begin
      errors++;
      $display("FAIL timeout_early: ndone=%0d done=%b seen0=%0d expected 0 00 999", ndone, done, seen0);
    end
    send_bytes(1);
    checks++;
    if (done !== 2'b01 || err !== 1 || rstart !== 0 || seen0 != 1) begin
      errors++;
      $display("FAIL timeout_done: done=%b err=%b rstart=%b seen0=%0d expected 01 1 0 1", done, err, rstart, seen0);
    end
    req_valid = 2'b11;
    send_bytes(500);
    checks++;
    if (seen0 + seen1 != 0 || ndone != 1 || nack != 0 || busy !== 1) begin
      errors++;
      $display("FAIL timeout_drain: strobes=%0d done_cycles=%0d acks=%0d busy=%b expected 0 1 0 1", seen0 + seen1, ndone, nack, busy);
    end
    rbusy = 0;
    step();
    checks++;
    if (busy !== 0 || req_ack !== 2'b00 || done !== 2'b00) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b ack=%b done=%b expected 0 00 00", busy, req_ack, done);
    end
    step();
    checks++;
    if (req_ack !== 2'b10 || rsector !== 32'h2) begin
      errors++;
      $display("FAIL timeout_regrant: ack=%b rsector=%h expected 10 00000002", req_ack, rsector);
    end
    req_valid = 0;
  endtask
  task automatic test_simultaneous();
    do_reset();
    req_valid = 2'b01; req_sector = {32'h0000_0abc, 32'h0000_0123};
    step();
    req_valid = 0;
    send_bytes(511);
    for (int i = 0; i < 488; i++) step();
    outen = 1; rdone = 1; rbusy = 1;
    step();
    outen = 0; rdone = 0; rbusy = 0;
    checks++;
    if (done !== 2'b01 || err !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL simul_done: done=%b err=%b busy=%b expected 01 0 0", done, err, busy);
    end
    req_valid = 2'b10;
    step();
    checks++;
    if (req_ack !== 2'b10 || rsector !== 32'habc) begin
      errors++;
      $display("FAIL simul_regrant: ack=%b rsector=%h expected 10 00000abc", req_ack, rsector);
    end
    req_valid = 0;
  endtask
  task automatic test_rst_mid();
    do_reset();
    req_valid = 2'b01; req_sector = {32'h0000_0055, 32'h0000_0044};
    step();
    req_valid = 0;
    send_bytes(100);
    rst = 1; outen = 1; rbusy = 1;
    step();
    rst = 0;
    checks++;
    if ({req_ack, done, err, rstart, busy, out_en} !== 9'b0 || rsector !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: ack=%b done=%b err=%b rstart=%b busy=%b out_en=%b rsector=%h expected all 0",
               req_ack, done, err, rstart, busy, out_en, rsector);
    end
    req_valid = 2'b10;
    send_bytes(20);
    checks++;
    if (nack != 0 || ndone != 0 || seen0 + seen1 != 0) begin
      errors++;
      $display("FAIL rst_mid_wait: acks=%0d dones=%0d strobes=%0d expected 0 0 0", nack, ndone, seen0 + seen1);
    end
    rbusy = 0;
    step();
    checks++;
    if (req_ack !== 2'b10 || rsector !== 32'h55 || done !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_grant: ack=%b rsector=%h done=%b expected 10 00000055 00", req_ack, rsector, done);
    end
    req_valid = 0;
  endtask
  task automatic test_drop();
    do_reset();
    rbusy = 1; req_valid = 2'b01; req_sector = 64'h7;
    step();
    step();
    req_valid = 0; rbusy = 0;
    step();
    step();
    checks++;
    if (req_ack !== 2'b00 || busy !== 0) begin
      errors++;
      $display("FAIL drop: ack=%b busy=%b expected 00 0", req_ack, busy);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_short();
    test_timeout();
    test_simultaneous();
    test_rst_mid();
    test_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_sector_arbiter.md
Name: sd_sector_arbiter

Overview:
- Shares one sd_reader sector-read engine between NREQ requesters, e.g. a UART dumper and a FAT/file parser.
- Picks one pending request by round-robin and drives rstart/rsector to the engine.
- Routes the 512-byte output stream only to the granted requester.
- Reports per-requester completion with a status: byte-count check plus watchdog timeout.
- Sits between the requesters and sd_reader, in the same clock domain.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 33554432, cycles allowed from rstart assertion to rdone before abort (~0.34 s at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  request pending, held until req_ack.
- req_sector  in  32*NREQ  sector number per requester; slice i is bits [32i+31:32i].
- req_ack  out  NREQ  one-cycle pulse: request accepted, sector latched.
- out_en  out  NREQ  byte strobe to the granted requester only.
- out_addr  out  9  byte index within the sector.
- out_byte  out  8  byte data.
- done  out  NREQ  one-cycle pulse: read finished for requester i.
- err  out  1  valid with done; 1 = timeout or byte count != 512.
- busy  out  1  1 when not IDLE.
- rstart  out  1  to sd_reader.
- rsector  out  32  to sd_reader.
- rbusy  in  1  from sd_reader.
- rdone  in  1  from sd_reader.
- outen  in  1  from sd_reader.
- outaddr  in  9  from sd_reader.
- outbyte  in  8  from sd_reader.

Behaviour:
- Reset state: IDLE, rr_ptr=NREQ-1. Outputs: req_ack=0, done=0, err=0, rstart=0, rsector=0, busy=0, out_en=0.
- All outputs except out_en/out_addr/out_byte are registered.

State machine:
- IDLE:
  - When any req_valid is set and rbusy=0, grant the first set bit scanning rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - Registered on that edge: req_ack[g]=1 (one cycle), gnt=g, rsector=req_sector[g], rstart=1, rr_ptr=g, byte_cnt=0, tmo_cnt=0. Go to READ.
  - If rbusy=1 in IDLE, no grant.
- READ:
  - out_en[i] = outen & (i==gnt), combinational. out_addr=outaddr, out_byte=outbyte pass through.
  - byte_cnt (10-bit, saturating at 1023) increments on each outen.
  - tmo_cnt increments every cycle.
  - rdone=1: rstart<=0, done[gnt]<=1 next cycle, err<=(byte_cnt_incl_this_cycle!=512). Go to IDLE.
  - tmo_cnt reaches TIMEOUT-1 without rdone: rstart<=0, done[gnt]<=1, err<=1. Go to DRAIN.
  - rdone and timeout on the same cycle: rdone wins (err from count only).
- DRAIN:
  - out_en forced 0; late bytes are discarded.
  - Wait for rbusy=0, then go to IDLE. No second done pulse.
- Latency:
  - req_valid rising in IDLE → req_ack and rstart one cycle later.
  - rdone → done one cycle later.
  - A new grant is possible on the cycle done is high, provided rbusy=0.
- Request handling:
  - req_valid deasserted before ack: request dropped silently.
  - req_sector changes after ack: no effect.
  - A requester holding req_valid after its ack is re-served only after the other pending requesters (fairness).
- rst mid-READ: immediately IDLE, rstart=0, no done pulse. The outstanding sd_reader operation finishes unobserved; the next grant waits for rbusy=0.
- err is held until the next done pulse; it is meaningful only with done.

Test Plan:
- Single request: req_valid[0]=1, sector 0x0000_0800 → req_ack[0] one cycle later, rsector=0x800, rstart=1. Model emits 512 outen bytes then rdone → out_en[1] never set, done[0]=1, err=0, rstart=0.
- Contention: req_valid=2'b11 from reset → grants in order 0,1,0,1 while both stay asserted. Each requester sees exactly 512 out_en strobes per grant.
- Short sector: model emits 500 bytes then rdone → done=1 with err=1; next grant proceeds normally.
- Timeout: TIMEOUT=1000, model never asserts rdone and holds rbusy=1 until cycle 1500 → done[gnt]=1 with err=1 at cycle 1000. Bytes arriving at cycles 1000..1500 give out_en=0; a new grant appears only after rbusy=0.
- Simultaneous rdone and timeout on cycle TIMEOUT-1 with 512 bytes seen → err=0, state IDLE (not DRAIN).
- rst pulsed mid-READ after 100 bytes → all outputs at reset values the next cycle, no done pulse. A pending request is granted only after the model drops rbusy.
